// File: rtl/buffer_port_arbiter_pkg.sv
// rtl/buffer_port_arbiter_pkg.sv - shared widths, lane select and arbiter state for the buffer port arbiter
package buffer_port_arbiter_pkg;

  localparam int AW_DEF    = 14;
  localparam int DW_DEF    = 8;
  // Low address bits pick the byte lane inside an 8-byte buffer word.
  localparam int LANE_BITS = 3;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [(1 << LANE_BITS)-1:0] lane_onehot(input logic [LANE_BITS-1:0] lane);
    return (1 << LANE_BITS)'(1) << lane;
  endfunction

endpackage

// File: rtl/buffer_port_arbiter_rr_pick.sv
// rtl/buffer_port_arbiter_rr_pick.sv - combinational rotating-priority picker, first request at or after ptr wins
module buffer_port_arbiter_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/buffer_port_arbiter.sv
// rtl/buffer_port_arbiter.sv - round-robin arbiter with burst lock and watchdog sharing one buffer byte port
module buffer_port_arbiter
  import buffer_port_arbiter_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int AW           = AW_DEF,
  parameter  int DW           = DW_DEF,
  parameter  int LOCK_TIMEOUT = 64,
  localparam int IW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [AW-1:0]      buf_addr,
  output logic               buf_we,
  output logic [DW-1:0]      buf_wdata,
  input  logic [DW-1:0]      buf_rdata,
  output logic [IW-1:0]      grant_id,
  output logic               locked,
  output logic               lock_timeout
);

  localparam int            CW       = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'(LOCK_TIMEOUT);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [CW-1:0]   idle_cnt, idle_cnt_nxt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;
  logic [IW-1:0]   acc_idx;
  logic            timeout_hit;
  logic            s1_valid, s2_valid;
  logic [IW-1:0]   s1_tag, s2_tag;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  buffer_port_arbiter_rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    idle_cnt_nxt = idle_cnt;
    req_ready    = '0;
    accept       = 1'b0;
    acc_idx      = pick_idx;
    timeout_hit  = 1'b0;
    case (state)
      ARB_OPEN: begin
        if (pick_any) begin
          req_ready    = pick_grant;
          accept       = 1'b1;
          idle_cnt_nxt = '0;
          if (req_last[pick_idx]) begin
            rr_ptr_nxt = next_idx(pick_idx);
          end else begin
            state_nxt = ARB_LOCKED;
            owner_nxt = pick_idx;
          end
        end
      end
      ARB_LOCKED: begin
        acc_idx = owner;
        // The watchdog release takes priority: the owner gets no beat in that cycle.
        if ((LOCK_TIMEOUT > 0) && (idle_cnt == IDLE_MAX)) begin
          timeout_hit  = 1'b1;
          state_nxt    = ARB_OPEN;
          rr_ptr_nxt   = next_idx(owner);
          idle_cnt_nxt = '0;
        end else if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          accept           = 1'b1;
          idle_cnt_nxt     = '0;
          if (req_last[owner]) begin
            state_nxt  = ARB_OPEN;
            rr_ptr_nxt = next_idx(owner);
          end
        end else if (LOCK_TIMEOUT > 0) begin
          idle_cnt_nxt = idle_cnt + CW'(1);
        end
      end
      default: state_nxt = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_OPEN;
      rr_ptr       <= '0;
      owner        <= '0;
      idle_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      owner        <= owner_nxt;
      idle_cnt     <= idle_cnt_nxt;
      lock_timeout <= timeout_hit;
    end
  end

  // Port drive and the 2-deep tag pipeline that lines up with the RAM's 1-cycle read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_addr  <= '0;
      buf_we    <= 1'b0;
      buf_wdata <= '0;
      grant_id  <= '0;
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
    end else begin
      buf_we   <= accept && req_we[acc_idx];
      s1_valid <= accept && !req_we[acc_idx];
      s1_tag   <= acc_idx;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (accept) begin
        buf_addr  <= req_addr[int'(acc_idx)*AW +: AW];
        buf_wdata <= req_wdata[int'(acc_idx)*DW +: DW];
        grant_id  <= acc_idx;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2_valid) rsp_valid[s2_tag] = 1'b1;
  end

  assign rsp_data = s2_valid ? buf_rdata : '0;
  assign locked   = (state == ARB_LOCKED);

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// tb/tb_buffer_port_arbiter.sv - directed and random checks of buffer_port_arbiter against a rule-level model
module tb_buffer_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int LT   = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_last, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]      rsp_data, buf_wdata, buf_rdata;
  logic [AW-1:0]      buf_addr;
  logic               buf_we, locked, lock_timeout;
  logic [1:0]         grant_id;

  buffer_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .buf_addr     (buf_addr),
    .buf_we       (buf_we),
    .buf_wdata    (buf_wdata),
    .buf_rdata    (buf_rdata),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    buf_rdata <= mem[buf_addr];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       tag;
    int       due;
    bit       known;
    bit [7:0] data;
  } rsp_t;

  int            m_ptr, m_owner, m_idle, cyc;
  bit            m_locked;
  bit [AW-1:0]   e_addr;
  bit            e_we, e_to;
  bit [DW-1:0]   e_wdata;
  int            e_grant;
  rsp_t          pend[$];
  bit [7:0]      shadow [int];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, bit v, bit l, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_we[i]    = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    req_valid = '0; req_last = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_locked) begin
      if (m_idle != LT && req_valid[m_owner]) r[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (r == '0 && req_valid[i]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_clock();
    int acc;
    bit to;
    acc = -1;
    to  = 1'b0;
    if (m_locked) begin
      if (m_idle == LT) begin
        to = 1'b1; m_locked = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_idle = 0;
      end else if (req_valid[m_owner]) begin
        acc = m_owner; m_idle = 0;
      end else begin
        m_idle++;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (acc < 0 && req_valid[i]) acc = i;
      end
    end
    e_to = to;
    if (acc >= 0) begin
      e_we    = req_we[acc];
      e_addr  = req_addr[acc*AW +: AW];
      e_wdata = req_wdata[acc*DW +: DW];
      e_grant = acc;
      if (e_we) shadow[int'(e_addr)] = e_wdata;
      else pend.push_back('{acc, cyc + 2, shadow.exists(int'(e_addr)),
                            shadow.exists(int'(e_addr)) ? shadow[int'(e_addr)] : 8'h00});
      if (req_last[acc]) begin
        m_locked = 1'b0; m_ptr = (acc + 1) % NREQ;
      end else begin
        m_locked = 1'b1; m_owner = acc;
      end
    end else begin
      e_we = 1'b0;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] exp_rv;
    exp_rv = '0;
    chk("buf_we", buf_we, e_we);
    chk("buf_addr", buf_addr, e_addr);
    chk("buf_wdata", buf_wdata, e_wdata);
    chk("grant_id", grant_id, e_grant);
    chk("locked", locked, m_locked);
    chk("lock_timeout", lock_timeout, e_to);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].tag] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (pend[0].known) chk("rsp_data", rsp_data, pend[0].data);
      void'(pend.pop_front());
    end else begin
      chk("rsp_valid", rsp_valid, exp_rv);
    end
  endtask

  task automatic step();
    #1;
    chk("req_ready", req_ready, model_ready());
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    clear_req();
    rst_n = 1'b0;
    #1;
    m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 1'b0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_grant = 0; e_to = 1'b0;
    pend.delete();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_buf", {buf_addr, buf_we, buf_wdata}, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    cyc = 0;
    rst_n = 1'b0;
    clear_req();
    @(negedge clk);
    do_reset();

    // single write then read-back
    set_req(0, 1, 1, 1, 14'h0010, 8'hA5);
    step();
    chk("t1_buf_we", buf_we, 1);
    chk("t1_buf_addr", buf_addr, 14'h0010);
    chk("t1_buf_wdata", buf_wdata, 8'hA5);
    clear_req();
    set_req(0, 1, 1, 0, 14'h0010, 8'h00);
    step();
    clear_req();
    step();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 8'hA5);
    step();

    // all requesters single-beat: strict rotation with wrap
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 0, 14'h0010, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_grant", grant_id, k % NREQ);
    end
    clear_req();
    step(); step();

    // req1 locked 4-beat read burst holds off req2
    do_reset();
    set_req(2, 1, 1, 0, 14'h0010, 8'h00);
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1, b == 3, 0, 14'h0010, 8'h00);
      #1;
      chk("burst_r2_blocked", req_ready[2], 0);
      step();
    end
    set_req(1, 0, 0, 0, 14'h0, 8'h0);
    #1;
    chk("burst_r2_ready", req_ready, 4'b0100);
    step();
    chk("burst_grant2", grant_id, 2);
    clear_req();
    step(); step();

    // watchdog release after the owner stalls
    do_reset();
    set_req(3, 1, 0, 1, 14'h0020, 8'h77);
    step();
    chk("wd_locked", locked, 1);
    set_req(3, 0, 0, 0, 14'h0, 8'h0);
    set_req(0, 1, 1, 0, 14'h0010, 8'h00);
    n = 0;
    while (n < 80 && !lock_timeout) begin
      step();
      n++;
    end
    chk("wd_delay", n, LT + 1);
    chk("wd_unlocked", locked, 0);
    #1;
    chk("wd_next_ready", req_ready, 4'b0001);
    step();
    chk("wd_next_grant", grant_id, 0);
    chk("wd_pulse_one_cycle", lock_timeout, 0);
    clear_req();
    step(); step();

    // back-to-back reads from two requesters
    do_reset();
    set_req(0, 1, 1, 1, 14'h0001, 8'h5C);
    step();
    clear_req();
    set_req(2, 1, 1, 1, 14'h0002, 8'h3E);
    step();
    clear_req();
    set_req(0, 1, 1, 0, 14'h0001, 8'h00);
    step();
    clear_req();
    set_req(2, 1, 1, 0, 14'h0002, 8'h00);
    step();
    chk("b2b_rsp0", rsp_valid, 4'b0001);
    chk("b2b_data0", rsp_data, 8'h5C);
    clear_req();
    step();
    chk("b2b_rsp2", rsp_valid, 4'b0100);
    chk("b2b_data2", rsp_data, 8'h3E);
    step();

    // reset with a read in flight
    set_req(1, 1, 1, 0, 14'h0010, 8'h00);
    step();
    do_reset();
    step();
    chk("rst_mid_rsp_a", rsp_valid, 0);
    step();
    chk("rst_mid_rsp_b", rsp_valid, 0);
    chk("rst_mid_locked", locked, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 1, 14'h0030, 8'h11);
    #1;
    chk("rst_mid_ptr0", req_ready, 4'b0001);
    step();
    clear_req();
    step();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                AW'($urandom_range(0, 15)), DW'($urandom));
      step();
    end
    clear_req();
    for (int c = 0; c < 4; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_port_arbiter.md
Name: buffer_port_arbiter

Overview:
- Round-robin arbiter sharing one byte-wide port of the PLB-side staging buffer among NREQ engine-side requesters.
- Supports single-beat and locked multi-beat bursts.
- Registers the port drive and returns read data with fixed latency, tagged to the issuing requester.
- Sits between the compute engines and one busN port of the buffer; the PLB port of the buffer is unaffected.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 14, buffer port address width in bytes.
- DW, 8, data width.
- LOCK_TIMEOUT, 64, idle cycles a lock owner may stall before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active low.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  beat ends the burst (releases lock).
- req_we  in  NREQ  1 = write beat, 0 = read beat.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies slice i.
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  beat accepted this cycle; one-hot or zero.
- rsp_valid  out  NREQ  read data valid for requester i; one-hot or zero.
- rsp_data  out  DW  read data; shared by all requesters, qualified by rsp_valid.
- buf_addr  out  AW  to buffer busN address.
- buf_we  out  1  to buffer busN write enable.
- buf_wdata  out  DW  to buffer busN write data.
- buf_rdata  in  DW  from buffer busN read data (synchronous RAM, 1-cycle read).
- grant_id  out  log2(NREQ)  current or last owner.
- locked  out  1  burst lock held.
- lock_timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0, owner=0, locked=0, idle counter=0, read pipeline cleared.
- Unlocked cycle:
  - Candidate = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[candidate]=1 combinationally; the beat is accepted this cycle (T).
  - If req_last=1: rr_ptr<=candidate+1 mod NREQ, stay unlocked.
  - If req_last=0: locked<=1, owner<=candidate.
- Locked cycle:
  - req_ready[owner]=req_valid[owner]; all other ready bits are 0.
  - Accepted beat with req_last=1: locked<=0, rr_ptr<=owner+1.
- Port drive:
  - An accepted beat at T drives buf_addr/buf_we/buf_wdata registered in T+1.
  - No accepted beat: buf_we<=0; buf_addr and buf_wdata hold.
  - grant_id<=the accepted requester.
- Read return:
  - Read beat accepted at T gives rsp_valid[i]=1 in T+2, with rsp_data=buf_rdata passed through.
  - 2-deep valid/tag pipeline; back-to-back reads give one response per cycle, in order.
  - Write beats produce no response.
- Watchdog:
  - While locked and req_valid[owner]=0, the idle counter increments; it clears on any owner beat or on unlock.
  - Counter reaching LOCK_TIMEOUT: locked<=0, rr_ptr<=owner+1, lock_timeout=1 for one cycle; no beat is accepted that cycle.
- Boundary conditions:
  - No requests: port idle, buf_we=0.
  - Single requester continuously valid with last=1: one beat per cycle.
  - rr_ptr wraps from NREQ-1 to 0.
  - Reset mid-burst: lock dropped and in-flight responses discarded (rsp_valid low after reset).
  - A requester's signals are sampled only when its ready is high.

Decomposition:
- Shared package: AW/DW defaults and the buffer lane-select constant (addr low 3 bits select the byte lane).
- Sub-module rr_pick: combinational rotating priority picker (req vector and rr_ptr in; one-hot grant and index out). Reused by the PLB-side scheduler.

Test Plan:
- Reset: all outputs 0. Req0 writes 0xA5 @0x0010 last=1 at T → req_ready[0]=1 at T; buf_we=1, buf_addr=0x0010, buf_wdata=0xA5 at T+1. Req0 reads 0x0010 → rsp_valid[0]=1, rsp_data=0xA5 two cycles after accept.
- All 4 requesters valid, single-beat, for 8 cycles → grants 0,1,2,3,0,1,2,3; the pointer wraps.
- Req1 issues a 4-beat read burst (last on beat 4) while req2 is valid → req_ready[2]=0 until the cycle after req1's last beat; next grant goes to req2.
- Req3 locks with last=0, then drops valid; LOCK_TIMEOUT=64 → lock_timeout pulses 64 cycles later, locked=0, req0 granted the following cycle.
- Back-to-back reads req0@0x0001 and req2@0x0002 in consecutive cycles → rsp_valid[0] then rsp_valid[2] on consecutive cycles, with correct data.
- rst_n asserted one cycle after a read is accepted → no rsp_valid after reset; locked=0, rr_ptr=0.
